pulse_cmd_arbiter: RTL and testbench

Shares one cross-domain control-pulse channel among `N_REQ` requesters in the tester's control logic. Each requester raises a level request. The block picks one pending requester round-robin and drives a stretched pulse plus a command code toward the pulse-detect synchronizer. It then holds a guard gap so the far domain sees distinct pulses, and waits for a returned acknowledge or a timeout before serving the next request.

---
 rtl/pulse_cmd_arbiter.sv | 178 +++++++++++++++++
 tb/tb_pulse_cmd_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_cmd_arbiter.sv
// pulse_cmd_arbiter
// Shares one cross-domain control-pulse channel among N_REQ requesters.
// Rising edges on req are latched as pending commands. An IDLE FSM picks one
// round-robin, drives a stretched registered pulse, then holds a guard gap,
// then waits for the far-domain acknowledge or a timeout.
//
// Ports:
//   clk          single clock for all state
//   rst_n        asynchronous active-low reset
//   req          level requests; each rising edge registers one command
//   ack_async    acknowledge level from the far domain (asynchronous)
//   grant        one-hot, one-cycle pulse marking the requester served
//   done         one-hot, one-cycle pulse on acknowledged completion
//   timeout_err  one-cycle pulse when the acknowledge never arrives
//   pulse_out    registered stretched pulse toward the synchronizer
//   sel_code     index of the active requester, held until back in IDLE
//   busy         high in every state except IDLE
module pulse_cmd_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned PULSE_LEN   = 11,
    parameter int unsigned GAP_LEN     = 12,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned CODE_W      = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic              ack_async,
    output logic [N_REQ-1:0]  grant,
    output logic [N_REQ-1:0]  done,
    output logic              timeout_err,
    output logic              pulse_out,
    output logic [CODE_W-1:0] sel_code,
    output logic              busy
);

    localparam int unsigned MaxPg  = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned MaxLen = (MaxPg > ACK_TIMEOUT) ? MaxPg : ACK_TIMEOUT;
    localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;

    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_LEN - 1);
    localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_LEN - 1);
    localparam logic [CntW-1:0] AckLoad   = CntW'(ACK_TIMEOUT - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StPulse = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;
    localparam logic [1:0] StWait  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CODE_W-1:0] sel_q, sel_d;
    logic [CODE_W-1:0] last_q, last_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              pulse_q, pulse_d;
    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [N_REQ-1:0]  req_dly_q;
    logic              ack_s1_q, ack_s2_q, ack_s3_q;
    logic              ack_seen_q, ack_seen_d;

    logic              ack_rise;
    logic              win_found;
    logic [CODE_W-1:0] win_idx;
    logic [CODE_W-1:0] cand;

    assign ack_rise = ack_s2_q & ~ack_s3_q;

    // A same-cycle new edge overrides the clear caused by the grant.
    assign pending_d = (pending_q & ~grant_q) | (req & ~req_dly_q);

    // Round-robin search starting just after the last served requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = CODE_W'((32'(last_q) + k) % N_REQ);
            if (!win_found && pending_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        grant_d     = '0;
        pulse_d     = pulse_q;
        ack_seen_d  = ack_seen_q;
        done        = '0;
        timeout_err = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d[win_idx] = 1'b1;
                    sel_d            = win_idx;
                    last_d           = win_idx;
                    pulse_d          = 1'b1;
                    cnt_d            = PulseLoad;
                    ack_seen_d       = 1'b0;
                    state_d          = StPulse;
                end
            end
            StPulse: begin
                if (ack_rise) ack_seen_d = 1'b1;
                if (cnt_q == '0) begin
                    pulse_d = 1'b0;
                    cnt_d   = GapLoad;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StGap: begin
                if (ack_rise) ack_seen_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = AckLoad;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWait: begin
                if (ack_rise) ack_seen_d = 1'b1;
                // Acknowledge takes priority over a coincident timeout.
                if (ack_seen_q || ack_rise) begin
                    done[sel_q] = 1'b1;
                    state_d     = StIdle;
                end else if (cnt_q == '0) begin
                    timeout_err = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sel_q      <= '0;
            last_q     <= CODE_W'(N_REQ - 1);
            grant_q    <= '0;
            pulse_q    <= 1'b0;
            pending_q  <= '0;
            req_dly_q  <= '0;
            ack_s1_q   <= 1'b0;
            ack_s2_q   <= 1'b0;
            ack_s3_q   <= 1'b0;
            ack_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            pulse_q    <= pulse_d;
            pending_q  <= pending_d;
            req_dly_q  <= req;
            ack_s1_q   <= ack_async;
            ack_s2_q   <= ack_s1_q;
            ack_s3_q   <= ack_s2_q;
            ack_seen_q <= ack_seen_d;
        end
    end

    assign grant     = grant_q;
    assign pulse_out = pulse_q;
    assign sel_code  = sel_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_pulse_cmd_arbiter.sv
// Self-checking bench for pulse_cmd_arbiter: directed scenarios plus a
// randomized run compared every cycle against a timeline-based model.
module tb_pulse_cmd_arbiter;

    localparam int N  = 4;
    localparam int PL = 11;
    localparam int GL = 12;
    localparam int AT = 64;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic          ack_async;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic          timeout_err;
    logic          pulse_out;
    logic [CW-1:0] sel_code;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pulse_cmd_arbiter #(
        .N_REQ       (N),
        .PULSE_LEN   (PL),
        .GAP_LEN     (GL),
        .ACK_TIMEOUT (AT),
        .CODE_W      (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .ack_async   (ack_async),
        .grant       (grant),
        .done        (done),
        .timeout_err (timeout_err),
        .pulse_out   (pulse_out),
        .sel_code    (sel_code),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a command is a timeline starting at its grant cycle
    // m_g; the phase follows from the elapsed cycle count alone.
    bit           m_active;
    int           m_g;
    int           m_sel;
    int           m_last;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_reqd;
    bit           m_seen;
    bit           h1, h2, h3;  // ack_async as sampled at the last three edges

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[CW'(i)] = 1'b1;
        return v;
    endfunction

    function automatic bit m_in_wait();
        return m_active && ((cyc - m_g) >= PL + GL);
    endfunction

    function automatic bit m_ackhit();
        return m_in_wait() && (m_seen || (h2 && !h3));
    endfunction

    function automatic logic [N-1:0] m_grant();
        return (m_active && cyc == m_g) ? onehot(m_sel) : '0;
    endfunction

    function automatic logic [N-1:0] m_done();
        return m_ackhit() ? onehot(m_sel) : '0;
    endfunction

    function automatic bit m_timeout();
        return m_in_wait() && !m_ackhit() && ((cyc - m_g) == PL + GL + AT - 1);
    endfunction

    function automatic bit m_pulse();
        return m_active && ((cyc - m_g) < PL);
    endfunction

    task automatic mdl_reset();
        m_active = 1'b0;
        m_g      = 0;
        m_sel    = 0;
        m_last   = N - 1;
        m_pend   = '0;
        m_reqd   = '0;
        m_seen   = 1'b0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    endtask

    // Advance one clock; the model steps on the rising edge using the
    // inputs held stable since the previous falling edge.
    task automatic tick();
        logic [N-1:0] g_c, d_c;
        bit           to_c, rise_c, found;
        int           w;
        @(posedge clk);
        if (rst_n) begin
            g_c    = m_grant();
            d_c    = m_done();
            to_c   = m_timeout();
            rise_c = h2 && !h3;
            found  = 1'b0;
            w      = 0;
            if (!m_active) begin
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (m_last + k) % N;
                    if (!found && m_pend[CW'(i)]) begin
                        found = 1'b1;
                        w     = i;
                    end
                end
                if (found) begin
                    m_active = 1'b1;
                    m_g      = cyc + 1;
                    m_sel    = w;
                    m_last   = w;
                    m_seen   = 1'b0;
                end
            end else begin
                if (rise_c) m_seen = 1'b1;
                if (d_c != '0 || to_c) m_active = 1'b0;
            end
            m_pend = (m_pend & ~g_c) | (req & ~m_reqd);
            m_reqd = req;
            h3 = h2; h2 = h1; h1 = ack_async;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req       = '0;
        ack_async = 1'b0;
        mdl_reset();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tick();
        n_checks++; if (pulse_out !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", pulse_out); end
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant); end
        n_checks++; if (done !== '0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (sel_code !== '0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel_code); end
    endtask

    task automatic test_single();
        int t0, g, gcnt, pcnt, dcyc, tocnt;
        logic [N-1:0]  gval, dval;
        logic [CW-1:0] gsel;
        logic          busy_after;
        apply_reset();
        t0 = cyc; g = -1000; gcnt = 0; pcnt = 0; dcyc = -1000; tocnt = 0;
        gval = '0; dval = '0; gsel = '0; busy_after = 1'b1;
        req = 4'b0100;
        for (int i = 0; i < 120; i++) begin
            if (i == 5) req = '0;
            if (i == 9) ack_async = 1'b1;
            tick();
            if (grant != '0) begin
                gcnt++;
                if (gcnt == 1) begin g = cyc; gval = grant; gsel = sel_code; end
            end
            if (pulse_out) pcnt++;
            if (timeout_err) tocnt++;
            if (done != '0 && dcyc < 0) begin dcyc = cyc; dval = done; end
            if (cyc == dcyc + 1) busy_after = busy;
        end
        ack_async = 1'b0;
        n_checks++; if (gcnt !== 1) begin n_fail++; $display("FAIL single_grant_count: got %0d want 1", gcnt); end
        n_checks++; if (gval !== 4'b0100) begin n_fail++; $display("FAIL single_grant_val: got %b want 0100", gval); end
        n_checks++; if (g !== t0 + 2) begin n_fail++; $display("FAIL single_grant_latency: got %0d want %0d", g - t0, 2); end
        n_checks++; if (gsel !== 2'd2) begin n_fail++; $display("FAIL single_sel: got %0d want 2", gsel); end
        n_checks++; if (pcnt !== PL) begin n_fail++; $display("FAIL single_pulse_len: got %0d want %0d", pcnt, PL); end
        n_checks++; if (dcyc !== g + PL + GL) begin n_fail++; $display("FAIL single_done_time: got %0d want %0d", dcyc - g, PL + GL); end
        n_checks++; if (dval !== 4'b0100) begin n_fail++; $display("FAIL single_done_val: got %b want 0100", dval); end
        n_checks++; if (tocnt !== 0) begin n_fail++; $display("FAIL single_no_timeout: got %0d want 0", tocnt); end
        n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", busy_after); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] order[$];
        int rises[$];
        int ack_hi, ack_lo, dcnt;
        logic prev;
        apply_reset();
        ack_hi = -1000; ack_lo = -1000; dcnt = 0; prev = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 200; i++) begin
            if (i == 1) req = '0;
            if (cyc == ack_hi) ack_async = 1'b1;
            if (cyc == ack_lo) ack_async = 1'b0;
            tick();
            if (grant != '0) begin
                order.push_back(grant);
                ack_hi = cyc + 4;
                ack_lo = cyc + 14;
            end
            if (pulse_out && !prev) rises.push_back(cyc);
            prev = pulse_out;
            if (done != '0) dcnt++;
        end
        ack_async = 1'b0;
        n_checks++; if (order.size() !== 4) begin n_fail++; $display("FAIL rr_grant_count: got %0d want 4", order.size()); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= order.size()) begin
                n_fail++; $display("FAIL rr_order[%0d]: got none want %b", k, onehot(k));
            end else if (order[k] !== onehot(k)) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %b want %b", k, order[k], onehot(k));
            end
        end
        for (int k = 1; k < rises.size(); k++) begin
            n_checks++;
            if (rises[k] - rises[k-1] < PL + GL + 1) begin
                n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want >= %0d", k, rises[k] - rises[k-1], PL + GL + 1);
            end
        end
        n_checks++; if (dcnt !== 4) begin n_fail++; $display("FAIL rr_done_count: got %0d want 4", dcnt); end
    endtask

    task automatic test_timeout();
        int g, tocnt, tocyc, dcnt;
        logic busy_next;
        apply_reset();
        g = -1000; tocnt = 0; tocyc = -1000; dcnt = 0; busy_next = 1'b1;
        req = 4'b0010;
        for (int i = 0; i < 150; i++) begin
            if (i == 1) req = '0;
            tick();
            if (grant != '0) g = cyc;
            if (timeout_err) begin tocnt++; tocyc = cyc; end
            if (done != '0) dcnt++;
            if (cyc == tocyc + 1) busy_next = busy;
        end
        n_checks++; if (tocnt !== 1) begin n_fail++; $display("FAIL to_count: got %0d want 1", tocnt); end
        // Timeout lands on the ACK_TIMEOUT-th WAIT_ACK cycle.
        n_checks++; if (tocyc !== g + PL + GL + AT - 1) begin n_fail++; $display("FAIL to_time: got %0d want %0d", tocyc - g, PL + GL + AT - 1); end
        n_checks++; if (dcnt !== 0) begin n_fail++; $display("FAIL to_no_done: got %0d want 0", dcnt); end
        n_checks++; if (busy_next !== 1'b0) begin n_fail++; $display("FAIL to_busy_fall: got %b want 0", busy_next); end
    endtask

    task automatic test_held_merged();
        int cnt[N];
        int ack_hi, ack_lo;
        logic [N-1:0] first;
        apply_reset();
        for (int k = 0; k < N; k++) cnt[k] = 0;
        ack_hi = -1000; ack_lo = -1000; first = '0;
        req = 4'b1010;
        for (int i = 0; i < 200; i++) begin
            if (i == 3)   req[3] = 1'b0;
            if (i == 6)   req[3] = 1'b1;
            if (i == 8)   req[3] = 1'b0;
            if (i == 10)  req[3] = 1'b1;
            if (i == 12)  req[3] = 1'b0;
            if (i == 100) req[1] = 1'b0;
            if (cyc == ack_hi) ack_async = 1'b1;
            if (cyc == ack_lo) ack_async = 1'b0;
            tick();
            if (grant != '0) begin
                if (first == '0) first = grant;
                for (int k = 0; k < N; k++) if (grant[k]) cnt[k]++;
                ack_hi = cyc + 4;
                ack_lo = cyc + 14;
            end
        end
        ack_async = 1'b0;
        n_checks++; if (first !== 4'b0010) begin n_fail++; $display("FAIL held_first: got %b want 0010", first); end
        n_checks++; if (cnt[1] !== 1) begin n_fail++; $display("FAIL held_req1_grants: got %0d want 1", cnt[1]); end
        n_checks++; if (cnt[3] !== 1) begin n_fail++; $display("FAIL merged_req3_grants: got %0d want 1", cnt[3]); end
        n_checks++; if (cnt[0] + cnt[2] !== 0) begin n_fail++; $display("FAIL held_other_grants: got %0d want 0", cnt[0] + cnt[2]); end
    endtask

    task automatic test_set_wins();
        int gcnt, g1, g2, d1, ack_hi, ack_lo;
        apply_reset();
        gcnt = 0; g1 = -1000; g2 = -1000; d1 = -1000; ack_hi = -1000; ack_lo = -1000;
        req = 4'b0001;
        for (int i = 0; i < 150; i++) begin
            if (i == 1) req = '0;
            if (cyc == g1 + 3) req[0] = 1'b0;
            if (cyc == ack_hi) ack_async = 1'b1;
            if (cyc == ack_lo) ack_async = 1'b0;
            tick();
            if (grant == 4'b0001) begin
                gcnt++;
                if (gcnt == 1) begin
                    g1 = cyc;
                    req[0] = 1'b1;  // edge sampled at the end of the grant cycle
                end else if (gcnt == 2) begin
                    g2 = cyc;
                end
                ack_hi = cyc + 4;
                ack_lo = cyc + 14;
            end
            if (done != '0 && d1 < 0) d1 = cyc;
        end
        ack_async = 1'b0;
        n_checks++; if (gcnt !== 2) begin n_fail++; $display("FAIL setwins_grants: got %0d want 2", gcnt); end
        n_checks++; if (g2 !== d1 + 2) begin n_fail++; $display("FAIL setwins_regrant_time: got %0d want %0d", g2 - d1, 2); end
    endtask

    task automatic test_reset_mid();
        int pc;
        apply_reset();
        pc = 0;
        req = 4'b0100;
        for (int i = 0; i < 40 && pc < 5; i++) begin
            if (i == 1) req = '0;
            if (i == 3) req = 4'b0001;
            if (i == 4) req = '0;
            tick();
            if (pulse_out) pc++;
        end
        n_checks++; if (pc !== 5) begin n_fail++; $display("FAIL rstmid_reach: got %0d want 5", pc); end
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        n_checks++; if (pulse_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulse: got %b want 0", pulse_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_checks++; if (dut.pending_q !== '0) begin n_fail++; $display("FAIL rstmid_pending: got %b want 0", dut.pending_q); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_busy: cycle %0d got %b want 0", i, busy); end
            n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL rstmid_idle_grant: cycle %0d got %b want 0", i, grant); end
            n_checks++; if (pulse_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_pulse: cycle %0d got %b want 0", i, pulse_out); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            // Second half acknowledges rarely so timeouts occur.
            if ($urandom_range(0, (i < 1500) ? 15 : 255) == 0) ack_async = ~ack_async;
            tick();
            n_checks++; if (grant !== m_grant()) begin n_fail++; $display("FAIL rnd_grant: cycle %0d got %b want %b", i, grant, m_grant()); end
            n_checks++; if (done !== m_done()) begin n_fail++; $display("FAIL rnd_done: cycle %0d got %b want %b", i, done, m_done()); end
            n_checks++; if (timeout_err !== m_timeout()) begin n_fail++; $display("FAIL rnd_timeout: cycle %0d got %b want %b", i, timeout_err, m_timeout()); end
            n_checks++; if (pulse_out !== m_pulse()) begin n_fail++; $display("FAIL rnd_pulse: cycle %0d got %b want %b", i, pulse_out, m_pulse()); end
            n_checks++; if (busy !== m_active) begin n_fail++; $display("FAIL rnd_busy: cycle %0d got %b want %b", i, busy, m_active); end
            n_checks++; if (sel_code !== CW'(m_sel)) begin n_fail++; $display("FAIL rnd_sel: cycle %0d got %0d want %0d", i, sel_code, m_sel); end
        end
        req = '0;
        ack_async = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        ack_async = 1'b0;
        mdl_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_held_merged();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
